// File: rtl/alu_seq_unit_pkg.sv
// Shared command codes, FSM state encoding and flag bundle for the
// registered execute-stage ALU.
package alu_seq_unit_pkg;

  localparam logic [3:0] ADD_EXECUTE = 4'b0000;
  localparam logic [3:0] SUB_EXECUTE = 4'b0010;
  localparam logic [3:0] AND_EXECUTE = 4'b0100;
  localparam logic [3:0] OR_EXECUTE  = 4'b0101;
  localparam logic [3:0] NOR_EXECUTE = 4'b0110;
  localparam logic [3:0] XOR_EXECUTE = 4'b0111;
  localparam logic [3:0] SLL_EXECUTE = 4'b1000;
  localparam logic [3:0] SRA_EXECUTE = 4'b1001;
  localparam logic [3:0] SRL_EXECUTE = 4'b1010;
  localparam logic [3:0] MUL_EXECUTE = 4'b1011;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DONE     = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic illegal;
  } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// WIDTH cycles after start; only the low WIDTH product bits are kept.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product_lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  // product_lo is the accumulator value after the current step, so the
  // parent can capture the final product on the same edge done is seen.
  assign product_lo = acc_q + (b_q[0] ? a_q : '0);
  assign done       = (cnt_q == CNT_W'(1));

  // NOTE: non-blocking assignments keep every register sampling the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      a_q   <= a;
      b_q   <= b;
      acc_q <= '0;
      cnt_q <= CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_q <= product_lo;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Registered execute-stage ALU with valid/ready handshakes, status flags and
// an optional iterative multiplier that stalls the input side while busy.
module alu_seq_unit
  import alu_seq_unit_pkg::*;
#(
  parameter int          WIDTH  = 32,
  parameter int          CMD_W  = 4,
  parameter int unsigned MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] valuein1,
  input  logic [WIDTH-1:0] valuein2,
  input  logic [CMD_W-1:0] EXE_CMD,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_overflow,
  output logic             illegal_cmd
);

  localparam int SH_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             accept, is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH:0]   add_w;
  logic [SH_W-1:0]  shamt;
  flags_t           flags_d;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;
  assign is_mul    = (EXE_CMD == CMD_W'(MUL_EXECUTE)) && (MUL_EN != 0);
  assign shamt     = valuein2[SH_W-1:0];
  assign add_w     = {1'b0, valuein1} + {1'b0, valuein2};

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    res_d   = '0;
    flags_d = '0;
    unique case (EXE_CMD)
      CMD_W'(ADD_EXECUTE): begin
        res_d            = add_w[WIDTH-1:0];
        flags_d.carry    = add_w[WIDTH];
        flags_d.overflow = (valuein1[WIDTH-1] == valuein2[WIDTH-1]) &&
                           (res_d[WIDTH-1] != valuein1[WIDTH-1]);
      end
      CMD_W'(SUB_EXECUTE): begin
        res_d            = valuein1 - valuein2;
        flags_d.carry    = (valuein1 < valuein2);
        flags_d.overflow = (valuein1[WIDTH-1] != valuein2[WIDTH-1]) &&
                           (res_d[WIDTH-1] != valuein1[WIDTH-1]);
      end
      CMD_W'(AND_EXECUTE): res_d = valuein1 & valuein2;
      CMD_W'(OR_EXECUTE):  res_d = valuein1 | valuein2;
      CMD_W'(NOR_EXECUTE): res_d = ~(valuein1 | valuein2);
      CMD_W'(XOR_EXECUTE): res_d = valuein1 ^ valuein2;
      CMD_W'(SLL_EXECUTE): res_d = valuein1 << shamt;
      CMD_W'(SRL_EXECUTE): res_d = valuein1 >> shamt;
      CMD_W'(SRA_EXECUTE): res_d = $signed(valuein1) >>> shamt;
      CMD_W'(MUL_EXECUTE): flags_d.illegal = (MUL_EN == 0);
      default:             flags_d.illegal = 1'b1;
    endcase
    flags_d.zero = (res_d == '0);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept) state_d = is_mul ? MUL_BUSY : DONE;
      MUL_BUSY: if (mul_done) state_d = DONE;
      DONE: begin
        if (accept)         state_d = is_mul ? MUL_BUSY : DONE;
        else if (out_ready) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Result registers only load on an accept or on multiplier completion,
  // which is what holds them stable while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result    <= '0;
      flag_zero     <= 1'b0;
      flag_carry    <= 1'b0;
      flag_overflow <= 1'b0;
      illegal_cmd   <= 1'b0;
    end else if (accept && !is_mul) begin
      alu_result    <= res_d;
      flag_zero     <= flags_d.zero;
      flag_carry    <= flags_d.carry;
      flag_overflow <= flags_d.overflow;
      illegal_cmd   <= flags_d.illegal;
    end else if ((state_q == MUL_BUSY) && mul_done) begin
      alu_result    <= mul_product;
      flag_zero     <= (mul_product == '0);
      flag_carry    <= 1'b0;
      flag_overflow <= 1'b0;
      illegal_cmd   <= 1'b0;
    end
  end

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk        (clk),
        .rst        (rst),
        .start      (accept && is_mul),
        .a          (valuein1),
        .b          (valuein2),
        .done       (mul_done),
        .product_lo (mul_product)
      );
    end else begin : g_no_mul
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

endmodule
